// File: rtl/rename_map_table.sv
// Register-rename map table: tracks the reservation-station tag that will
// produce each architectural register, answers operand lookups for issue,
// and turns matching CDB broadcasts into register-file writes.
module rename_map_table #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32,
    parameter int NUM_CDB  = 2,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic [REG_W-1:0]         rs1_addr,
    input  logic [REG_W-1:0]         rs2_addr,
    input  logic                     rs1_used,
    input  logic                     rs2_used,
    input  logic                     rs2_store,
    output logic [TAG_W-1:0]         T1,
    output logic [TAG_W-1:0]         T2,
    output logic [TAG_W-1:0]         T3,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
    output logic [NUM_CDB-1:0]       rf_we,
    output logic [NUM_CDB*REG_W-1:0] rf_waddr,
    output logic [NUM_CDB*XLEN-1:0]  rf_wdata,
    output logic [REG_W:0]           busy_count
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_n;
    logic [TAG_W-1:0]    tags   [NUM_REGS];
    logic [TAG_W-1:0]    tags_n [NUM_REGS];
    logic [REG_W:0]      count_n;

    logic [NUM_CDB-1:0]  hit;
    logic [REG_W-1:0]    hit_idx [NUM_CDB];
    logic                dup_tag;

    logic [TAG_W-1:0]    t1_raw, t2_raw, t3_raw;
    logic [TAG_W-1:0]    lk_tag;
    logic [TAG_W-1:0]    ct;
    logic                lower_dup;

    // Operand lookup on current state; a tag broadcast this cycle reads as ready.
    always_comb begin
        t1_raw = '0;
        t2_raw = '0;
        t3_raw = '0;
        lk_tag = '0;
        if (rs1_used && busy[rs1_addr])
            t1_raw = tags[rs1_addr];
        if (rs2_used && !rs2_store && busy[rs2_addr])
            t2_raw = tags[rs2_addr];
        if (rs2_store && busy[rs2_addr])
            t3_raw = tags[rs2_addr];
        T1 = t1_raw;
        T2 = t2_raw;
        T3 = t3_raw;
        for (int k = 0; k < NUM_CDB; k++) begin
            lk_tag = cdb_tag[k*TAG_W +: TAG_W];
            if (cdb_valid[k]) begin
                if (t1_raw == lk_tag) T1 = '0;
                if (t2_raw == lk_tag) T2 = '0;
                if (t3_raw == lk_tag) T3 = '0;
            end
        end
    end

    // Per-port CDB match against busy entries; a repeated tag on a higher port is ignored.
    always_comb begin
        hit       = '0;
        dup_tag   = 1'b0;
        ct        = '0;
        lower_dup = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            hit_idx[k] = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            ct        = cdb_tag[k*TAG_W +: TAG_W];
            lower_dup = 1'b0;
            for (int j = 0; j < k; j++)
                if (cdb_valid[j] && (cdb_tag[j*TAG_W +: TAG_W] == ct))
                    lower_dup = 1'b1;
            if (cdb_valid[k] && lower_dup)
                dup_tag = 1'b1;
            if (cdb_valid[k] && !lower_dup) begin
                // x0 is never busy, so the search starts at entry 1.
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (busy[i] && (tags[i] == ct)) begin
                        hit[k]     = 1'b1;
                        hit_idx[k] = REG_W'(i);
                    end
                end
            end
        end
    end

    // Next-state table: CDB clears first, issue overrides, flush wipes everything.
    always_comb begin
        busy_n = busy;
        for (int i = 0; i < NUM_REGS; i++)
            tags_n[i] = tags[i];
        for (int k = 0; k < NUM_CDB; k++) begin
            if (hit[k]) begin
                busy_n[hit_idx[k]] = 1'b0;
                tags_n[hit_idx[k]] = '0;
            end
        end
        if (issue_valid && (issue_rd != '0) && (issue_tag != '0)) begin
            busy_n[issue_rd] = 1'b1;
            tags_n[issue_rd] = issue_tag;
        end
        if (flush) begin
            busy_n = '0;
            for (int i = 0; i < NUM_REGS; i++)
                tags_n[i] = '0;
        end
        count_n = '0;
        for (int i = 0; i < NUM_REGS; i++)
            count_n = count_n + {{REG_W{1'b0}}, busy_n[i]};
    end

    // Map-table state and busy population count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy       <= '0;
            busy_count <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                tags[i] <= '0;
        end else begin
            busy       <= busy_n;
            busy_count <= count_n;
            for (int i = 0; i < NUM_REGS; i++)
                tags[i] <= tags_n[i];
        end
    end

    // Register-file write ports, one cycle behind the CDB; address/data hold when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_we    <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                rf_we[k] <= hit[k] && !flush;
                if (hit[k] && !flush) begin
                    rf_waddr[k*REG_W +: REG_W] <= hit_idx[k];
                    rf_wdata[k*XLEN +: XLEN]   <= cdb_val[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Two ports broadcasting the same tag means the producers are broken.
    always_ff @(posedge CLK) begin
        if (!RST)
            assert (!dup_tag) else $error("rename_map_table: duplicate valid CDB tag");
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed scenarios followed by random traffic,
// all checked against a reg->tag map model (0 = value ready).
module tb_rename_map_table;

    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 4;
    localparam int XLEN     = 32;
    localparam int NUM_CDB  = 2;
    localparam int REG_W    = 5;

    logic                     CLK = 1'b0;
    logic                     RST = 1'b1;
    logic                     flush = 1'b0;
    logic                     issue_valid = 1'b0;
    logic [REG_W-1:0]         issue_rd = '0;
    logic [TAG_W-1:0]         issue_tag = '0;
    logic [REG_W-1:0]         rs1_addr = '0;
    logic [REG_W-1:0]         rs2_addr = '0;
    logic                     rs1_used = 1'b0;
    logic                     rs2_used = 1'b0;
    logic                     rs2_store = 1'b0;
    logic [TAG_W-1:0]         T1, T2, T3;
    logic [NUM_CDB-1:0]       cdb_valid = '0;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
    logic [NUM_CDB*XLEN-1:0]  cdb_val = '0;
    logic [NUM_CDB-1:0]       rf_we;
    logic [NUM_CDB*REG_W-1:0] rf_waddr;
    logic [NUM_CDB*XLEN-1:0]  rf_wdata;
    logic [REG_W:0]           busy_count;

    rename_map_table #(
        .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)
    ) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs2_store(rs2_store),
        .T1(T1), .T2(T2), .T3(T3),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_count(busy_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: map[r] = producer tag, 0 when the register value is ready.
    int           map [NUM_REGS];
    logic [1:0]   e_we;
    int           e_addr [NUM_CDB];
    logic [31:0]  e_data [NUM_CDB];
    int           e_count;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int cdb_tag_of(int k);
        return int'(cdb_tag[k*TAG_W +: TAG_W]);
    endfunction

    function automatic int lookup(int a, bit en);
        int t;
        t = (en && a != 0) ? map[a] : 0;
        for (int k = 0; k < NUM_CDB; k++)
            if (cdb_valid[k] && t != 0 && t == cdb_tag_of(k))
                t = 0;
        return t;
    endfunction

    task automatic set_idle();
        flush = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0; rs2_store = 1'b0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic issue(input int rd, input int tag);
        issue_valid = 1'b1;
        issue_rd    = REG_W'(rd);
        issue_tag   = TAG_W'(tag);
    endtask

    task automatic cdb(input int k, input int tag, input logic [31:0] val);
        cdb_valid[k]               = 1'b1;
        cdb_tag[k*TAG_W +: TAG_W]  = TAG_W'(tag);
        cdb_val[k*XLEN +: XLEN]    = val;
    endtask

    // One clock: check lookups on current inputs, advance the model, check registered outputs.
    task automatic do_cycle();
        int new_map [NUM_REGS];
        int t;
        bit dup;
        #1;
        check("T1", T1, lookup(rs1_addr, rs1_used));
        check("T2", T2, lookup(rs2_addr, rs2_used && !rs2_store));
        check("T3", T3, lookup(rs2_addr, rs2_store));
        if (RST) begin
            foreach (map[r]) map[r] = 0;
            e_we = '0;
            for (int k = 0; k < NUM_CDB; k++) begin e_addr[k] = 0; e_data[k] = '0; end
        end else if (flush) begin
            foreach (map[r]) map[r] = 0;
            e_we = '0;
        end else begin
            new_map = map;
            for (int k = 0; k < NUM_CDB; k++) begin
                e_we[k] = 1'b0;
                t   = cdb_tag_of(k);
                dup = 1'b0;
                for (int j = 0; j < k; j++)
                    if (cdb_valid[j] && cdb_tag_of(j) == t) dup = 1'b1;
                if (cdb_valid[k] && !dup && t != 0) begin
                    for (int r = 1; r < NUM_REGS; r++) begin
                        if (map[r] == t) begin
                            e_we[k]    = 1'b1;
                            e_addr[k]  = r;
                            e_data[k]  = cdb_val[k*XLEN +: XLEN];
                            new_map[r] = 0;
                        end
                    end
                end
            end
            if (issue_valid && issue_rd != 0 && issue_tag != 0)
                new_map[issue_rd] = int'(issue_tag);
            map = new_map;
        end
        e_count = 0;
        foreach (map[r]) if (map[r] != 0) e_count++;
        @(posedge CLK);
        #1;
        check("rf_we", rf_we, e_we);
        for (int k = 0; k < NUM_CDB; k++) begin
            check($sformatf("rf_waddr%0d", k), rf_waddr[k*REG_W +: REG_W], e_addr[k]);
            check($sformatf("rf_wdata%0d", k), rf_wdata[k*XLEN +: XLEN], e_data[k]);
        end
        check("busy_count", busy_count, e_count);
    endtask

    task automatic rand_cycle();
        int busy_list[$];
        int free_tags[$];
        bit used;
        set_idle();
        rs1_addr  = REG_W'($urandom_range(0, NUM_REGS-1));
        rs2_addr  = REG_W'($urandom_range(0, NUM_REGS-1));
        rs1_used  = 1'($urandom_range(0, 1));
        rs2_used  = 1'($urandom_range(0, 1));
        rs2_store = ($urandom_range(0, 3) == 0);
        foreach (map[r]) if (map[r] != 0) busy_list.push_back(r);
        for (int t = 1; t < 16; t++) begin
            used = 1'b0;
            foreach (map[r]) if (map[r] == t) used = 1'b1;
            if (!used) free_tags.push_back(t);
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (busy_list.size() > 0 && $urandom_range(0, 9) < 7)
                    cdb(k, map[busy_list[$urandom_range(0, busy_list.size()-1)]], $urandom);
                else
                    cdb(k, $urandom_range(0, 15), $urandom);
            end
        end
        if (cdb_valid[0] && cdb_valid[1] && cdb_tag_of(0) == cdb_tag_of(1))
            cdb_valid[1] = 1'b0;
        if ($urandom_range(0, 9) < 6) begin
            if ($urandom_range(0, 15) == 0)
                issue($urandom_range(0, NUM_REGS-1), 0);
            else if (free_tags.size() > 0)
                issue($urandom_range(0, NUM_REGS-1), free_tags[$urandom_range(0, free_tags.size()-1)]);
        end
        flush = ($urandom_range(0, 39) == 0);
        RST   = ($urandom_range(0, 199) == 0);
        do_cycle();
        RST = 1'b0;
    endtask

    initial begin
        // Reset with unknown prior state; model starts clean.
        set_idle();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        foreach (map[r]) map[r] = 0;
        e_we = '0;
        for (int k = 0; k < NUM_CDB; k++) begin e_addr[k] = 0; e_data[k] = '0; end
        RST = 1'b0;
        check("rst_rf_we", rf_we, 2'b00);
        check("rst_rf_waddr", rf_waddr, 10'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        check("rst_busy_count", busy_count, 6'd0);

        // 1: lookups after reset
        set_idle(); rs1_addr = 5; rs2_addr = 6; rs1_used = 1; rs2_used = 1;
        #1;
        check("t1_T1", T1, 0); check("t1_T2", T2, 0); check("t1_T3", T3, 0);
        do_cycle();

        // 2: issue, lookup, CDB bypass and writeback
        set_idle(); issue(5, 3); do_cycle();
        set_idle(); rs1_addr = 5; rs1_used = 1;
        #1; check("t2_T1_busy", T1, 3);
        do_cycle();
        set_idle(); rs1_addr = 5; rs1_used = 1; cdb(0, 3, 32'hDEADBEEF);
        #1; check("t2_T1_bypass", T1, 0);
        do_cycle();
        check("t2_rf_we", rf_we, 2'b01);
        check("t2_waddr0", rf_waddr[4:0], 5);
        check("t2_wdata0", rf_wdata[31:0], 32'hDEADBEEF);
        check("t2_busy_count", busy_count, 0);

        // 3: stale tag after rename; issue beats CDB on the same register
        set_idle(); issue(7, 2); do_cycle();
        set_idle(); issue(7, 4); do_cycle();
        set_idle(); cdb(0, 2, 32'h1111_1111); rs1_addr = 7; rs1_used = 1;
        #1; check("t3_T1_renamed", T1, 4);
        do_cycle();
        check("t3_stale_we", rf_we, 2'b00);
        check("t3_held_waddr0", rf_waddr[4:0], 5);
        set_idle(); issue(7, 6); cdb(0, 4, 32'h2222_2222); do_cycle();
        check("t3_we", rf_we, 2'b01);
        check("t3_waddr0", rf_waddr[4:0], 7);
        check("t3_wdata0", rf_wdata[31:0], 32'h2222_2222);
        check("t3_busy_count", busy_count, 1);
        set_idle(); rs1_addr = 7; rs1_used = 1;
        #1; check("t3_T1_new", T1, 6);
        do_cycle();

        // 4: two CDB ports retire in one cycle
        set_idle(); cdb(0, 6, 32'h3333_3333); do_cycle();
        set_idle(); issue(1, 1); do_cycle();
        set_idle(); issue(2, 2); do_cycle();
        check("t4_busy2", busy_count, 2);
        set_idle(); cdb(0, 2, 32'hAAAA_0002); cdb(1, 1, 32'hBBBB_0001); do_cycle();
        check("t4_rf_we", rf_we, 2'b11);
        check("t4_waddr0", rf_waddr[4:0], 2);
        check("t4_waddr1", rf_waddr[9:5], 1);
        check("t4_wdata1", rf_wdata[63:32], 32'hBBBB_0001);
        check("t4_busy0", busy_count, 0);

        // 5: x0 protection and STORE data tag
        set_idle(); issue(0, 5); rs1_addr = 0; rs1_used = 1; do_cycle();
        check("t5_x0_count", busy_count, 0);
        set_idle(); rs1_addr = 0; rs1_used = 1;
        #1; check("t5_x0_T1", T1, 0);
        set_idle(); issue(9, 7); do_cycle();
        set_idle(); rs2_addr = 9; rs2_store = 1; rs2_used = 1;
        #1; check("t5_T3", T3, 7); check("t5_T2", T2, 0);
        do_cycle();

        // 6: flush beats issue; reset during a CDB cycle
        set_idle(); issue(3, 1); do_cycle();
        set_idle(); issue(4, 2); do_cycle();
        set_idle(); issue(8, 3); do_cycle();
        set_idle(); flush = 1; issue(10, 5); rs1_addr = 3; rs1_used = 1;
        #1; check("t6_T1_flush_cycle", T1, 1);
        do_cycle();
        check("t6_flush_count", busy_count, 0);
        check("t6_flush_we", rf_we, 2'b00);
        set_idle(); rs1_addr = 3; rs1_used = 1; rs2_addr = 10; rs2_used = 1;
        #1; check("t6_T1", T1, 0); check("t6_T2", T2, 0);
        do_cycle();
        set_idle(); issue(11, 9); do_cycle();
        set_idle(); cdb(0, 9, 32'h5555_5555); RST = 1; do_cycle(); RST = 0;
        check("t6_rst_we", rf_we, 2'b00);
        check("t6_rst_waddr", rf_waddr, 10'd0);
        check("t6_rst_wdata", rf_wdata, 64'd0);
        check("t6_rst_count", busy_count, 0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++)
            rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
